// File: rtl/bit_pack_pkg.sv
// -----------------------------------------------------------------------------
// bit_pack_pkg
// Shared constants and helpers for the 16-bit serial-to-parallel bit packer.
//   IWIDTH  : packed output word width (bits)
//   CNT_W   : width of the bit-position counter (0..IWIDTH-1)
//   LEN_W   : width of the valid-bit count carried with each word (1..IWIDTH)
// -----------------------------------------------------------------------------
package bit_pack_pkg;

  localparam int IWIDTH = 16;
  localparam int CNT_W  = 4;
  localparam int LEN_W  = 5;

  // Counter value of the last bit position in a word.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IWIDTH - 1);

  // One emitted word with its side information, as seen on the output port.
  typedef struct packed {
    logic              last;
    logic [LEN_W-1:0]  len;
    logic [IWIDTH-1:0] word;
  } word_t;

  // Number of valid bits in a word that closes while the counter reads c
  // (the closing bit itself is included).
  function automatic logic [LEN_W-1:0] len_of(input logic [CNT_W-1:0] c);
    return {1'b0, c} + LEN_W'(1);
  endfunction

endpackage

// File: rtl/bit_demux16.sv
// -----------------------------------------------------------------------------
// bit_demux16
// Decodes the current bit position plus an accept strobe into a one-hot write
// enable for the assembly register. Position k enables bit k, which makes the
// write path the exact inverse of a 16:1 bit-select read with select value k.
//   sel : bit position (counter value)
//   en  : a beat is accepted this cycle
//   we  : one-hot write enable, all zero when en is low
// -----------------------------------------------------------------------------
module bit_demux16
  import bit_pack_pkg::*;
(
  input  logic [CNT_W-1:0]  sel,
  input  logic              en,
  output logic [IWIDTH-1:0] we
);

  always_comb begin
    we = '0;
    if (en) begin
      we[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/bit_pack16.sv
// -----------------------------------------------------------------------------
// bit_pack16
// Packs a serial bit stream into 16-bit words. The first accepted bit of a
// word lands in out_word[0]. A word closes on its 16th bit or on a beat with
// in_last set; a partial word carries zeros in the unwritten positions and
// out_len tells how many bits are valid.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_bit, in_last     : serial data bit and end-of-row marker
//   in_valid, in_ready  : input handshake
//   out_word, out_len,
//   out_last            : packed word, valid-bit count (1..16), row-end flag
//   out_valid, out_ready: output handshake
//
// Handshake: on both sides a transfer happens on a rising edge where valid and
// ready are both high; valid never depends on ready, and once out_valid is
// raised the payload holds stable until it is taken. in_ready does not look at
// in_valid.
// -----------------------------------------------------------------------------
module bit_pack16 #(
  parameter int IWIDTH = bit_pack_pkg::IWIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_bit,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic [IWIDTH-1:0]              out_word,
  output logic [bit_pack_pkg::LEN_W-1:0] out_len,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready
);

  import bit_pack_pkg::*;

  // Only the 16-bit configuration is implemented.
  if (IWIDTH != 16) begin : g_bad_width
    $error("bit_pack16: IWIDTH must be 16");
  end

  logic [CNT_W-1:0]  cnt_q;
  logic [IWIDTH-1:0] asm_q;
  logic [IWIDTH-1:0] asm_next;
  logic [IWIDTH-1:0] bit_we;
  logic              at_end;
  logic              would_close;
  logic              accept;
  logic              closing;
  logic              consume;
  logic              out_blocked;

  assign at_end      = (cnt_q == CNT_MAX);
  // in_last is looked at without in_valid so that in_ready stays independent
  // of in_valid; the beat it refers to only matters once in_valid is high.
  assign would_close = at_end || in_last;
  // The output register is busy unless it is empty or is being drained.
  assign out_blocked = out_valid && !out_ready;

  // Stall only a beat that would need the output register while it is busy;
  // every other beat just writes the assembly register.
  assign in_ready = !(out_blocked && would_close);

  assign accept  = in_valid && in_ready;
  assign closing = accept && would_close;
  assign consume = out_valid && out_ready;

  bit_demux16 u_demux (
    .sel (cnt_q),
    .en  (accept),
    .we  (bit_we)
  );

  // Assembly register including the bit accepted this cycle; the output
  // register loads this value so the closing bit is not lost.
  assign asm_next = (asm_q & ~bit_we) | (bit_we & {IWIDTH{in_bit}});

  // Bit counter and assembly register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else if (closing) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + CNT_W'(1);
      asm_q <= asm_next;
    end
  end

  // Output register. A close always wins over a consume, so a word closing in
  // the same cycle the previous one is taken keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_word  <= '0;
      out_len   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (closing) begin
      out_word  <= asm_next;
      out_len   <= len_of(cnt_q);
      out_last  <= in_last;
      out_valid <= 1'b1;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_pack16.sv
// -----------------------------------------------------------------------------
// tb_bit_pack16
// Directed bench for bit_pack16. Stimulus pushes the expected word into exp_q;
// a monitor pops and compares on every output handshake and checks that a
// stalled word stays stable.
// -----------------------------------------------------------------------------
module tb_bit_pack16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [15:0] out_word;
  logic [4:0]  out_len;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int words_seen = 0;
  int beats_done = 0;

  logic [21:0] exp_q[$];
  int          hs_cyc[$];

  bit_pack16 #(.IWIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_len   (out_len),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic logic [21:0] mk(input logic [15:0] w, input logic [4:0] l,
                                     input logic last);
    return {last, l, w};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Presents one beat and holds it until accepted (bounded wait).
  task automatic send_beat(input logic b, input logic l);
    int waits;
    waits = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", waits);
      in_valid = 1'b0;
      in_bit   = 1'b0;
      in_last  = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      beats_done++;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic send_word(input logic [15:0] w, input logic last16);
    for (int k = 0; k < 16; k++) begin
      send_beat(w[k], last16 && (k == 15));
    end
  endtask

  // Idle cycles with garbage on in_bit that must not be captured.
  task automatic idle_noise(input int n);
    in_valid = 1'b0;
    in_bit   = 1'b1;
    tick(n);
    in_bit   = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic        stall_prev;
    logic [22:0] held;
    logic [21:0] e;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_stable", {9'b0, out_valid, out_last, out_len, out_word},
                {9'b0, held});
        end
        if (out_valid && out_ready) begin
          words_seen++;
          hs_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: got word 0x%0h len %0d last %0b, expected none",
                     out_word, out_len, out_last);
          end else begin
            e = exp_q.pop_front();
            check("out_word", out_word, e[15:0]);
            check("out_len", out_len, e[20:16]);
            check("out_last", out_last, e[21]);
          end
        end
        stall_prev = out_valid && !out_ready;
        held = {1'b1, out_last, out_len, out_word};
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish by 200000ns, expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    logic [31:0] pat;
    int          start;
    int          low_cnt;
    int          ws;

    // Reset state
    rst_n = 1'b0;
    tick(3);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", out_word, 0);
    check("rst_out_len", out_len, 0);
    check("rst_out_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // Full word 1,0,1,0,... -> 0x5555
    out_ready = 1'b1;
    exp_q.push_back(mk(16'h5555, 5'd16, 1'b0));
    for (int k = 0; k < 15; k++) send_beat((k % 2) == 0, 1'b0);
    check("t1_no_early_valid", out_valid, 0);
    send_beat(1'b0, 1'b0);
    check("t1_latency", out_valid, 1);
    tick(1);
    check("t1_drain", out_valid, 0);

    // Partial row: five ones, last on the fifth
    exp_q.push_back(mk(16'h001F, 5'd5, 1'b1));
    for (int k = 0; k < 4; k++) send_beat(1'b1, 1'b0);
    send_beat(1'b1, 1'b1);
    check("t2_valid", out_valid, 1);
    tick(2);

    // Backpressure across 32 continuous beats
    out_ready = 1'b0;
    pat = 32'h1234_ABCD;
    exp_q.push_back(mk(16'hABCD, 5'd16, 1'b0));
    exp_q.push_back(mk(16'h1234, 5'd16, 1'b0));
    beats_done = 0;
    fork
      begin
        for (int k = 0; k < 32; k++) send_beat(pat[k], 1'b0);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (in_ready && n < 200) begin
          n++;
          @(negedge clk);
        end
        check("t3_in_ready_low", in_ready, 0);
        check("t3_stall_point", beats_done, 31);
        repeat (3) @(negedge clk);
        check("t3_first_held", out_word, 16'hABCD);
        check("t3_first_valid", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    check("t3_second_loaded", out_word, 16'h1234);
    check("t3_valid_kept", out_valid, 1);
    tick(2);

    // Full throughput: 48 beats, three words 16 cycles apart
    out_ready = 1'b1;
    exp_q.push_back(mk(16'hFFFF, 5'd16, 1'b0));
    exp_q.push_back(mk(16'h0000, 5'd16, 1'b0));
    exp_q.push_back(mk(16'hC3A5, 5'd16, 1'b0));
    hs_cyc.delete();
    start = cyc;
    low_cnt = 0;
    fork
      begin
        send_word(16'hFFFF, 1'b0);
        send_word(16'h0000, 1'b0);
        send_word(16'hC3A5, 1'b0);
      end
      begin
        repeat (48) begin
          @(negedge clk);
          if (!in_ready) low_cnt++;
        end
      end
    join
    check("t4_beat_cycles", cyc - start, 48);
    check("t4_in_ready_low_cycles", low_cnt, 0);
    tick(2);
    check("t4_word_count", hs_cyc.size(), 3);
    if (hs_cyc.size() >= 3) begin
      check("t4_spacing_1", hs_cyc[1] - hs_cyc[0], 16);
      check("t4_spacing_2", hs_cyc[2] - hs_cyc[1], 16);
    end

    // Reset mid-word with a pending output word
    out_ready = 1'b0;
    send_word(16'hFFFF, 1'b0);
    for (int k = 0; k < 7; k++) send_beat(1'b1, 1'b0);
    check("t5_pending_before_reset", out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_out_word", out_word, 0);
    check("t5_rst_out_len", out_len, 0);
    check("t5_rst_out_last", out_last, 0);
    check("t5_rst_in_ready", in_ready, 1);
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    out_ready = 1'b1;
    ws = words_seen;
    exp_q.push_back(mk(16'h0001, 5'd16, 1'b0));
    send_word(16'h0001, 1'b0);
    tick(4);
    check("t5_one_word", words_seen - ws, 1);

    // in_last on the 16th beat, with ignored idle cycles mid-word
    ws = words_seen;
    exp_q.push_back(mk(16'h8001, 5'd16, 1'b1));
    for (int k = 0; k < 16; k++) begin
      send_beat(k == 0 || k == 15, k == 15);
      if (k == 3) idle_noise(2);
    end
    tick(20);
    check("t6_one_word", words_seen - ws, 1);

    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
